// File: rtl/sign_mag_bcd_conv.sv
// ---------------------------------------------------------------------------
// sign_mag_bcd_conv
//
// Converts an N-bit sign-magnitude word (bit N-1 = sign, bits N-2:0 =
// magnitude) into a sign flag, a negative-zero flag and DIGITS packed BCD
// digits. The conversion uses a serial double-dabble engine that consumes
// one magnitude bit per clock.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. The producer holds valid and data stable until
// that edge. The consumer may hold ready low for any number of cycles.
// in_ready is decoded from the state register only, so out_ready never
// reaches in_ready combinationally.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   in_valid     in_sm holds a word to convert
//   in_ready     block can accept a word (high only in IDLE)
//   in_sm        sign-magnitude operand
//   out_valid    result valid, held until accepted
//   out_ready    consumer accepts the result
//   out_neg      result is negative (0 for a zero magnitude)
//   out_negzero  input was -0
//   out_bcd      packed BCD, digit 0 in bits 3:0
//
// The FSM state is held in the enum signal `state`, so checkers can bind
// to it hierarchically.
// ---------------------------------------------------------------------------
module sign_mag_bcd_conv #(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_sm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_neg,
    output logic                  out_negzero,
    output logic [4*DIGITS-1:0]   out_bcd
);

    localparam int MAG_W = N - 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(N);

    function automatic longint unsigned pow10(input int d);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < d; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_MAG = (64'd1 << MAG_W) - 64'd1;

    // The digit count must be able to hold the largest magnitude, so the
    // shift register can never overflow.
    generate
        if (N < 2) begin : g_bad_n
            $error("sign_mag_bcd_conv: N must be at least 2");
        end
        if (pow10(DIGITS) <= MAX_MAG) begin : g_bad_digits
            $error("sign_mag_bcd_conv: DIGITS too small for N-1 magnitude bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [MAG_W-1:0]     mag_sr;
    logic [BCD_W-1:0]     bcd_sr;
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_next;
    logic [CNT_W-1:0]     cnt;
    logic                 sign_r;
    logic                 negzero_r;

    assign in_ready = (state == IDLE);

    // Double-dabble step: every digit >= 5 is corrected by +3 from the
    // pre-shift value, then the magnitude MSB shifts into digit 0 bit 0.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BCD_W-2:0], mag_sr[MAG_W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mag_sr      <= '0;
            bcd_sr      <= '0;
            cnt         <= '0;
            sign_r      <= 1'b0;
            negzero_r   <= 1'b0;
            out_valid   <= 1'b0;
            out_neg     <= 1'b0;
            out_negzero <= 1'b0;
            out_bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_sr    <= in_sm[MAG_W-1:0];
                        sign_r    <= in_sm[N-1];
                        negzero_r <= in_sm[N-1] & (in_sm[MAG_W-1:0] == '0);
                        bcd_sr    <= '0;
                        cnt       <= CNT_W'(N - 1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= bcd_next;
                    mag_sr <= mag_sr << 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Last shift: publish the finished digits on the same
                    // edge so out_bcd equals the final bcd_sr in DONE.
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_bcd     <= bcd_next;
                        out_neg     <= sign_r & ~negzero_r;
                        out_negzero <= negzero_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_mag_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_sign_mag_bcd_conv
//
// Two instances share one clock and reset: an N=8/DIGITS=3 converter and an
// N=4/DIGITS=1 converter fed from a behavioural sign-magnitude adder.
// Drivers push the reference result into a per-instance queue when a word
// is accepted; monitors pop and compare whenever an output appears.
// ---------------------------------------------------------------------------
module tb_sign_mag_bcd_conv;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic        out_neg8, out_negzero8;
    logic [7:0]  in_sm8;
    logic [11:0] out_bcd8;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic        out_neg4, out_negzero4;
    logic [3:0]  in_sm4;
    logic [3:0]  out_bcd4;

    sign_mag_bcd_conv #(.N(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_sm(in_sm8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_neg(out_neg8), .out_negzero(out_negzero8), .out_bcd(out_bcd8)
    );

    sign_mag_bcd_conv #(.N(4), .DIGITS(1)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_sm(in_sm4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_neg(out_neg4), .out_negzero(out_negzero4), .out_bcd(out_bcd4)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [13:0] exp8_q[$];   // {neg, negzero, bcd[11:0]}
    int          acc8_q[$];   // cycle index of acceptance edge
    logic [5:0]  exp4_q[$];   // {neg, negzero, bcd[3:0]}
    int          acc4_q[$];

    bit          pend8 = 0, hs8 = 0, pend4 = 0, hs4 = 0;
    logic [13:0] held8;
    logic [5:0]  held4;
    bit          rand_rdy8 = 0, rand_rdy4 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // ---------------- reference models ----------------
    function automatic logic [13:0] model8(input logic [7:0] v);
        int m;
        logic [11:0] b;
        m = int'(v[6:0]);
        b = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
        return {v[7] && (m != 0), v[7] && (m == 0), b};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] v);
        int m;
        m = int'(v[2:0]);
        return {v[3] && (m != 0), v[3] && (m == 0), 4'(m % 10)};
    endfunction

    // Sign-magnitude sum of two 4-bit words, magnitude wrapped to 3 bits.
    function automatic logic [3:0] sm_add4(input logic [3:0] a, input logic [3:0] b);
        int va, vb, s, m;
        va = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
        vb = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        return {s < 0, 3'(m % 8)};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send8(input logic [7:0] v);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid8 = 1'b1;
        in_sm8    = v;
        while (!done && n < 400) begin
            @(negedge clk);
            if (in_ready8 && !rst) begin
                exp8_q.push_back(model8(v));
                acc8_q.push_back(cyc + 1);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) timeout("accept8");
        in_valid8 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] v);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid4 = 1'b1;
        in_sm4    = v;
        while (!done && n < 400) begin
            @(negedge clk);
            if (in_ready4 && !rst) begin
                exp4_q.push_back(model4(v));
                acc4_q.push_back(cyc + 1);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) timeout("accept4");
        in_valid4 = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while ((exp8_q.size() != 0 || pend8) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) timeout("drain8");
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while ((exp4_q.size() != 0 || pend4) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) timeout("drain4");
    endtask

    // Random consumer backpressure, enabled per instance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy8) out_ready8 = ($urandom_range(0, 3) != 0);
            if (rand_rdy4) out_ready4 = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst) begin
            pend8 = 0;
            hs8   = 0;
            exp8_q.delete();
            acc8_q.delete();
        end else begin
            if (hs8) begin
                check("drop8", out_valid8, 0);
                hs8 = 0;
            end
            if (out_valid8) begin
                if (!pend8) begin
                    if (exp8_q.size() == 0) begin
                        check("extra8", 1, 0);
                    end else begin
                        check("data8", {out_neg8, out_negzero8, out_bcd8}, exp8_q.pop_front());
                        check("lat8", cyc - acc8_q.pop_front(), 7);
                    end
                    held8 = {out_neg8, out_negzero8, out_bcd8};
                    pend8 = 1;
                end else begin
                    check("hold8", {out_neg8, out_negzero8, out_bcd8}, held8);
                end
                check("in_ready8_busy", in_ready8, 0);
                if (out_ready8) begin
                    pend8 = 0;
                    hs8   = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend4 = 0;
            hs4   = 0;
            exp4_q.delete();
            acc4_q.delete();
        end else begin
            if (hs4) begin
                check("drop4", out_valid4, 0);
                hs4 = 0;
            end
            if (out_valid4) begin
                if (!pend4) begin
                    if (exp4_q.size() == 0) begin
                        check("extra4", 1, 0);
                    end else begin
                        check("data4", {out_neg4, out_negzero4, out_bcd4}, exp4_q.pop_front());
                        check("lat4", cyc - acc4_q.pop_front(), 3);
                    end
                    held4 = {out_neg4, out_negzero4, out_bcd4};
                    pend4 = 1;
                end else begin
                    check("hold4", {out_neg4, out_negzero4, out_bcd4}, held4);
                end
                check("in_ready4_busy", in_ready4, 0);
                if (out_ready4) begin
                    pend4 = 0;
                    hs4   = 1;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; in_sm8 = '0; out_ready8 = 1'b0;
        in_valid4 = 1'b0; in_sm4 = '0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state of both instances
        check("rst_valid8",   out_valid8,   0);
        check("rst_ready8",   in_ready8,    1);
        check("rst_bcd8",     out_bcd8,     0);
        check("rst_neg8",     out_neg8,     0);
        check("rst_negzero8", out_negzero8, 0);
        check("rst_valid4",   out_valid4,   0);
        check("rst_ready4",   in_ready4,    1);
        check("rst_bcd4",     out_bcd4,     0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // +127, -127, -0 with the consumer always ready
        out_ready8 = 1'b1;
        send8(8'h7F);
        send8(8'hFF);
        send8(8'h80);
        drain8();

        // Backpressure on +42 while the next word (-5) waits upstream
        out_ready8 = 1'b0;
        send8(8'h2A);
        fork
            send8(8'h85);
            begin
                int n;
                n = 0;
                while (!out_valid8 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) timeout("valid8_rise");
                repeat (5) @(posedge clk);
                #1;
                out_ready8 = 1'b1;
            end
        join
        drain8();

        // Reset between edges in the middle of a conversion of 100
        send8(8'h64);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid8",   out_valid8,   0);
        check("midrst_ready8",   in_ready8,    1);
        check("midrst_bcd8",     out_bcd8,     0);
        check("midrst_neg8",     out_neg8,     0);
        check("midrst_negzero8", out_negzero8, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send8(8'h8A);
        drain8();

        // Every 8-bit code with random stalls and random input gaps
        rand_rdy8 = 1;
        for (int i = 0; i < 256; i++) begin
            send8(8'(i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain8();
        rand_rdy8 = 0;
        out_ready8 = 1'b1;

        // N=4 instance: spot codes, then adder sums of all a/b pairs
        rand_rdy4 = 1;
        send4(4'hF);
        send4(4'h8);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send4(sm_add4(4'(a), 4'(b)));
            end
        end
        drain4();
        rand_rdy4 = 0;

        check("left8", exp8_q.size(), 0);
        check("left4", exp4_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
